// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction-fetch stage with credit-limited prefetch queue
// Sequential fetch over req/gnt + rvalid, in-order response queue, redirect flush with stale-response discard.
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] branchAddr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] instAddr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] memInst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] next_pc
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, outstanding, discard;
    logic [CW:0]       credit_used;
    logic              issue, rsp_ok, push, pop;

    // A request slot is only offered when the queue can absorb every in-flight response.
    always_comb begin
        credit_used = {1'b0, count} + {1'b0, outstanding};
        imem_req    = !rst && (credit_used < DEPTH_C) && !PCSrc;
        issue       = imem_req && imem_gnt;
        rsp_ok      = imem_rvalid && (outstanding != '0);
        push        = rsp_ok && (discard == '0) && !PCSrc;
        pop         = inst_valid && inst_ready && !PCSrc;
    end

    assign instAddr   = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign next_pc    = inst_pc + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (PCSrc) begin
            // Everything still in flight after this cycle belongs to the abandoned path.
            fetch_pc    <= branchAddr;
            resp_pc     <= branchAddr;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp_ok);
            discard     <= outstanding - CW'(rsp_ok);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            outstanding <= outstanding + CW'(issue) - CW'(rsp_ok);
            if (rsp_ok && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                q_inst[wr_ptr] <= memInst;
                q_pc[wr_ptr]   <= resp_pc;
                wr_ptr         <= wr_ptr + PW'(1);
                resp_pc        <= resp_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    credit_bound: assert property (@(posedge clk) disable iff (rst) credit_used <= DEPTH_C);
endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized bench for if_prefetch against an in-order fetch-stream model
module tb_if_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [15:0] RPC16 = 16'hFFE0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCSrc, imem_gnt, imem_rvalid, inst_ready;
    logic [31:0] branchAddr, memInst;
    logic        imem_req, inst_valid;
    logic [31:0] instAddr, inst, inst_pc, next_pc;

    logic        pcsrc16, gnt16, rvalid16, ready16, req16, valid16;
    logic [15:0] baddr16, addr16, pc16, npc16;
    logic [31:0] mem16, inst16;

    if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .branchAddr(branchAddr),
        .imem_req(imem_req), .instAddr(instAddr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .memInst(memInst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .next_pc(next_pc));

    if_prefetch #(.ADDR_W(16), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RPC16)) dut16 (
        .clk(clk), .rst(rst), .PCSrc(pcsrc16), .branchAddr(baddr16),
        .imem_req(req16), .instAddr(addr16), .imem_gnt(gnt16),
        .imem_rvalid(rvalid16), .memInst(mem16), .inst_valid(valid16),
        .inst_ready(ready16), .inst(inst16), .inst_pc(pc16), .next_pc(npc16));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // knobs
    int          gnt_pct, ready_pct, lat_lo, lat_hi, redir_pct;
    logic        rst_k, redir_k;
    logic [31:0] redir_addr;

    // memory and stream model
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          last_due, cyc, n_gnt, n_acc;
    logic [31:0] exp_pc, last_acc_pc, prev_addr, watch_addr;
    logic        prev_hold;
    int          watch_gnt, watch_valid;
    logic        req16_q, seen_wrap;
    logic [15:0] addr16_q, exp16;

    task automatic cycle();
        int          lat;
        logic [31:0] np;
        logic [15:0] np16;
        @(negedge clk);
        cyc++;
        rst         = rst_k;
        imem_rvalid = 1'b0;
        memInst     = '0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            memInst     = word_of(mq_addr[0]);
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        imem_gnt   = ($urandom_range(99) < gnt_pct);
        inst_ready = ($urandom_range(99) < ready_pct);
        PCSrc      = redir_k || (redir_pct > 0 && $urandom_range(99) < redir_pct);
        branchAddr = redir_k ? redir_addr : ($urandom() & 32'hFFFF_FFFC);
        rvalid16   = req16_q;
        mem16      = word_of({16'h0, addr16_q});
        #1;
        if (rst) begin
            exp_pc    = RPC;
            exp16     = RPC16;
            prev_hold = 1'b0;
            req16_q   = 1'b0;
        end else begin
            if (prev_hold) check("addr_stable", 64'(instAddr), 64'(prev_addr));
            if (PCSrc) check("req_off_on_redirect", 64'(imem_req), 64'd0);
            if (imem_req && imem_gnt) begin
                lat      = $urandom_range(lat_hi, lat_lo);
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                mq_addr.push_back(instAddr);
                mq_due.push_back(last_due);
                n_gnt++;
                if (instAddr == watch_addr && watch_gnt < 0) watch_gnt = cyc;
            end
            if (inst_valid && !PCSrc && watch_gnt >= 0 && watch_valid < 0 && inst_pc == watch_addr)
                watch_valid = cyc;
            if (inst_valid && inst_ready && !PCSrc) begin
                np = exp_pc + 32'd4;
                check("inst_pc", 64'(inst_pc), 64'(exp_pc));
                check("inst_word", 64'(inst), 64'(word_of(exp_pc)));
                check("next_pc", 64'(next_pc), 64'(np));
                exp_pc      = np;
                last_acc_pc = inst_pc;
                n_acc++;
            end
            if (PCSrc) exp_pc = branchAddr;
            prev_hold = imem_req && !imem_gnt && !PCSrc;
            prev_addr = instAddr;
            if (valid16) begin
                np16 = exp16 + 16'd4;
                check("pc16", 64'(pc16), 64'(exp16));
                check("word16", 64'(inst16), 64'(word_of({16'h0, exp16})));
                check("next_pc16", 64'(npc16), 64'(np16));
                if (exp16 == 16'hFFFC) begin
                    seen_wrap = 1'b1;
                    check("wrap16", 64'(npc16), 64'd0);
                end
                exp16 = np16;
            end
            req16_q  = req16;
            addr16_q = addr16;
        end
    endtask

    task automatic do_reset();
        rst_k = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        last_due = 0;
        repeat (2) cycle();
        rst_k = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int          t0, fv, a, k;
        logic        found;
        logic [31:0] a0;
        logic [31:0] pcs [2];
        rst = 1'b1; PCSrc = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        branchAddr = '0; memInst = '0;
        pcsrc16 = 1'b0; gnt16 = 1'b1; ready16 = 1'b1; rvalid16 = 1'b0; baddr16 = '0; mem16 = '0;
        cyc = 0; n_gnt = 0; n_acc = 0; last_due = 0; exp_pc = RPC; exp16 = RPC16;
        prev_hold = 1'b0; prev_addr = '0; last_acc_pc = '0; req16_q = 1'b0; addr16_q = '0;
        seen_wrap = 1'b0; watch_addr = 32'hFFFF_FFFF; watch_gnt = -1; watch_valid = -1;
        gnt_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1; redir_pct = 0;
        redir_k = 1'b0; redir_addr = '0;

        // reset values, then zero-wait streaming
        rst_k = 1'b1;
        repeat (3) cycle();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_next_pc", 64'(next_pc), 64'd4);
        check("rst_addr", 64'(instAddr), 64'(RPC));
        rst_k = 1'b0;
        t0 = cyc + 1;
        fv = -1;
        for (int i = 0; i < 10 && fv < 0; i++) begin
            cycle();
            if (inst_valid) fv = cyc;
        end
        check("first_valid_lat", 64'(fv - t0), 64'd2);
        a = n_acc;
        repeat (20) cycle();
        check("throughput", 64'(n_acc - a), 64'd20);

        // decode stall fills the queue and stops fetching
        ready_pct = 0;
        repeat (10) cycle();
        check("stall_valid", 64'(inst_valid), 64'd1);
        check("stall_req", 64'(imem_req), 64'd0);
        check("stall_inflight", 64'(mq_addr.size()), 64'd0);
        check("stall_held", 64'(n_gnt - n_acc), 64'(DEPTH));
        ready_pct = 100;
        a = n_acc;
        repeat (10) cycle();
        check("resume_flow", 64'(n_acc - a), 64'd10);

        // redirect with three slow responses in flight
        do_reset();
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = (mq_addr.size() == 3);
        end
        check("three_in_flight", 64'(found), 64'd1);
        watch_addr = 32'h100; watch_gnt = -1; watch_valid = -1;
        redir_k = 1'b1; redir_addr = 32'h100;
        cycle();
        redir_k = 1'b0;
        a = n_acc; k = 0;
        for (int i = 0; i < 30 && k < 2; i++) begin
            cycle();
            if (n_acc > a + k) begin
                pcs[k] = last_acc_pc;
                k++;
            end
        end
        check("redir_pc0", 64'(pcs[0]), 64'h100);
        check("redir_pc1", 64'(pcs[1]), 64'h104);
        check("redir_gnt_gap", 64'(watch_gnt >= 0 && watch_valid - watch_gnt >= 2), 64'd1);

        // redirect coincident with rvalid, push and pop
        lat_lo = 1; lat_hi = 1;
        repeat (10) cycle();
        redir_k = 1'b1; redir_addr = 32'h2000;
        cycle();
        redir_k = 1'b0;
        check("coinc_rvalid", 64'(imem_rvalid), 64'd1);
        check("coinc_valid", 64'(inst_valid), 64'd1);
        cycle();
        check("flush_empty", 64'(inst_valid), 64'd0);
        check("flush_req", 64'(imem_req), 64'd1);
        check("flush_addr", 64'(instAddr), 64'h2000);
        cycle();
        check("flush_empty2", 64'(inst_valid), 64'd0);
        cycle();
        check("flush_first_valid", 64'(inst_valid), 64'd1);
        check("flush_first_pc", 64'(inst_pc), 64'h2000);

        // grant withheld
        gnt_pct = 0;
        cycle();
        a0 = instAddr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("gnt_low_addr", 64'(instAddr), 64'(a0));
            check("gnt_low_req", 64'(imem_req), 64'd1);
        end
        gnt_pct = 100;
        a = n_acc;
        repeat (8) cycle();
        check("gnt_resume_flow", 64'(n_acc - a), 64'd6);

        // reset with two requests outstanding, late responses afterwards
        do_reset();
        lat_lo = 8; lat_hi = 8;
        repeat (2) cycle();
        gnt_pct = 0;
        check("pre_rst_inflight", 64'(mq_addr.size()), 64'd2);
        rst_k = 1'b1;
        cycle();
        rst_k = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("late_rvalid_ignored", 64'(inst_valid), 64'd0);
            check("restart_addr", 64'(instAddr), 64'(RPC));
        end
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        a = n_acc;
        repeat (6) cycle();
        check("restart_flow", 64'(n_acc - a), 64'd4);

        // random traffic with random redirects
        do_reset();
        gnt_pct = 60; ready_pct = 70; lat_lo = 1; lat_hi = 4; redir_pct = 4;
        a = n_acc;
        repeat (600) cycle();
        redir_pct = 0; gnt_pct = 100; ready_pct = 100;
        repeat (20) cycle();
        check("random_progress", 64'(n_acc - a > 50), 64'd1);
        check("wrap16_seen", 64'(seen_wrap), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
